// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter_if
//  Purpose  : Issue, EX/LD writeback, operand query and RF write-port bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) ();
    logic                  iss_valid;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic                  iss_ready;
    logic                  ex_valid;
    logic [ADDR_WIDTH-1:0] ex_addr;
    logic [DATA_WIDTH-1:0] ex_data;
    logic                  ex_ready;
    logic                  ld_valid;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_ready;
    logic [ADDR_WIDTH-1:0] ra;
    logic [ADDR_WIDTH-1:0] rb;
    logic                  ra_busy;
    logic                  rb_busy;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  err;

    modport master (
        output iss_valid, iss_addr, ex_valid, ex_addr, ex_data,
               ld_valid, ld_addr, ld_data, ra, rb,
        input  iss_ready, ex_ready, ld_ready, ra_busy, rb_busy,
               rf_wen, rf_waddr, rf_wdata, err
    );

    modport slave (
        input  iss_valid, iss_addr, ex_valid, ex_addr, ex_data,
               ld_valid, ld_addr, ld_data, ra, rb,
        output iss_ready, ex_ready, ld_ready, ra_busy, rb_busy,
               rf_wen, rf_waddr, rf_wdata, err
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Round-robin EX/LD arbitration onto the RF write port with a
//             per-register pending-write scoreboard for RAW detection.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 2
) (
    input  wire logic            clk,
    input  wire logic            rstn,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int                    c_NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0]  c_CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0]  c_CNT_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] c_X0       = '0;

    typedef enum logic [0:0] {
        PTR_EX = 1'b0,
        PTR_LD = 1'b1
    } ptr_t;

    ptr_t                  r_ptr;
    logic [CNT_WIDTH-1:0]  r_cnt [c_NUM_REGS];
    logic                  r_rf_wen;
    logic [ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0] r_rf_wdata;
    logic                  r_err;

    logic                  w_ex_grant;
    logic                  w_ld_grant;
    logic                  w_wb_fire;
    logic [ADDR_WIDTH-1:0] w_wb_addr;
    logic [DATA_WIDTH-1:0] w_wb_data;
    logic                  w_wb_counts;
    logic                  w_iss_ready;
    logic                  w_iss_counts;
    logic                  w_same;
    logic                  w_underflow;

    // The pointer only breaks ties; a lone requester is always granted.
    assign w_ex_grant = rstn && bus.ex_valid && (!bus.ld_valid || (r_ptr == PTR_EX));
    assign w_ld_grant = rstn && bus.ld_valid && (!bus.ex_valid || (r_ptr == PTR_LD));
    assign w_wb_fire  = w_ex_grant || w_ld_grant;
    assign w_wb_addr  = w_ex_grant ? bus.ex_addr : bus.ld_addr;
    assign w_wb_data  = w_ex_grant ? bus.ex_data : bus.ld_data;

    // x0 never takes part in the scoreboard, so it can neither block nor underflow.
    assign w_wb_counts  = w_wb_fire && (w_wb_addr != c_X0);
    assign w_iss_ready  = rstn && ((bus.iss_addr == c_X0)
                                   || (r_cnt[bus.iss_addr] != c_CNT_MAX)
                                   || (w_wb_counts && (w_wb_addr == bus.iss_addr)));
    assign w_iss_counts = bus.iss_valid && w_iss_ready && (bus.iss_addr != c_X0);
    assign w_same       = w_iss_counts && w_wb_counts && (bus.iss_addr == w_wb_addr);
    assign w_underflow  = w_wb_counts && !w_same && (r_cnt[w_wb_addr] == c_CNT_ZERO);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_cnt[i] <= c_CNT_ZERO;
            end
            r_ptr      <= PTR_EX;
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_err      <= 1'b0;
        end else begin
            // When both hit the same register they cancel; otherwise the addresses differ.
            if (w_iss_counts && !w_same) begin
                r_cnt[bus.iss_addr] <= r_cnt[bus.iss_addr] + 1'b1;
            end
            if (w_wb_counts && !w_same && !w_underflow) begin
                r_cnt[w_wb_addr] <= r_cnt[w_wb_addr] - 1'b1;
            end
            if (w_underflow) begin
                r_err <= 1'b1;
            end
            if (w_wb_fire) begin
                r_ptr      <= w_ex_grant ? PTR_LD : PTR_EX;
                r_rf_waddr <= w_wb_addr;
                r_rf_wdata <= w_wb_data;
            end
            r_rf_wen <= w_wb_counts;
        end
    end

    // A register stays busy while its result sits in the write stage.
    assign bus.ra_busy = (bus.ra != c_X0)
                         && ((r_cnt[bus.ra] != c_CNT_ZERO) || (r_rf_wen && (r_rf_waddr == bus.ra)));
    assign bus.rb_busy = (bus.rb != c_X0)
                         && ((r_cnt[bus.rb] != c_CNT_ZERO) || (r_rf_wen && (r_rf_waddr == bus.rb)));

    assign bus.iss_ready = w_iss_ready;
    assign bus.ex_ready  = w_ex_grant;
    assign bus.ld_ready  = w_ld_grant;
    assign bus.rf_wen    = r_rf_wen;
    assign bus.rf_waddr  = r_rf_waddr;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sequences the single write port of the 32-entry general-purpose register file between two writeback requesters: the execute unit (EX) and the load unit (LD).
- Keeps a per-register pending-write scoreboard so the decode stage can detect RAW hazards on source operands.
- Sits between EX/LD writeback and the register file write port (wdata/waddr/w_en).

Parameters:
ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)
DATA_WIDTH, 32, register data width
CNT_WIDTH, 2, width of the per-register pending counter (max outstanding = 2**CNT_WIDTH-1)

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
iss_valid  input  1  decode issues an instruction that will write iss_addr
iss_addr  input  ADDR_WIDTH  destination register of the issued instruction
iss_ready  output  1  issue accepted (counter for iss_addr not saturated)
ex_valid  input  1  EX writeback request
ex_addr  input  ADDR_WIDTH  EX destination register
ex_data  input  DATA_WIDTH  EX result
ex_ready  output  1  EX request granted this cycle
ld_valid  input  1  LD writeback request
ld_addr  input  ADDR_WIDTH  LD destination register
ld_data  input  DATA_WIDTH  LD result
ld_ready  output  1  LD request granted this cycle
ra  input  ADDR_WIDTH  source operand A query
rb  input  ADDR_WIDTH  source operand B query
ra_busy  output  1  write to ra still pending
rb_busy  output  1  write to rb still pending
rf_wen  output  1  register file write enable (registered)
rf_waddr  output  ADDR_WIDTH  register file write address (registered)
rf_wdata  output  DATA_WIDTH  register file write data (registered)
err  output  1  sticky: writeback with no matching pending issue

Behaviour:
- Reset: rstn is synchronous and active-low; clock is clk. On reset, all pending counters go to 0. rf_wen=0, rf_waddr=0, rf_wdata=0, err=0, and the round-robin pointer points to EX. While rstn=0, iss_ready, ex_ready and ld_ready are forced to 0.
- Handshake: a transfer fires when valid && ready. ready is combinational from the valids and the pointer. Requesters hold addr/data stable until they fire.
- Arbitration: exactly one grant per cycle.
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted.
  - After any grant, the pointer moves to the other requester. The pointer is unchanged when there is no grant.
- Write stage: one-cycle latency. On fire at cycle N, rf_wen/rf_waddr/rf_wdata take the granted values at edge N+1 and are held for one cycle. rf_wen returns to 0 if nothing fires.
- x0: a writeback to address 0 is accepted (ready per arbitration) but rf_wen stays 0. Issues to x0 are always ready and never count. ra/rb=0 are never busy.
- Scoreboard:
  - One CNT_WIDTH-bit counter per register.
  - An issue fire (iss_valid && iss_ready) increments cnt[iss_addr].
  - A writeback fire decrements cnt[granted addr].
  - Issue and writeback to the same register in the same cycle: counter unchanged.
- iss_ready = (cnt[iss_addr] != max) or a writeback to iss_addr fires this cycle.
- Underflow: a writeback fire to a register with cnt=0 leaves the counter at 0 and sets err=1 (sticky until reset). The write is still performed.
- Busy: ra_busy = (cnt[ra]!=0) || (rf_wen && rf_waddr==ra && ra!=0). rb_busy is identical using rb. This covers the cycle in which the write is in the output register.
- Reset mid-operation: reset overrides everything. Any in-flight write stage is dropped (rf_wen=0 at the next edge) and all counters are cleared.

Test Plan:
- Reset, then iss x5; next cycle EX ex_addr=5 ex_data=0xDEADBEEF -> ex_ready=1; at next edge rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; ra=5 busy through that cycle, then 0.
- Issue x3 and x4. EX(x3, 0x11) and LD(x4, 0x22) valid together for 2 cycles -> cycle1 grants EX, cycle2 grants LD; writes appear in order 3/0x11 then 4/0x22.
- Issue x7 three times -> 4th issue iss_ready=0; same cycle LD writeback x7 -> iss_ready=1, counter stays 3; rb=7 busy until 3 writebacks done.
- Writeback EX to x0 with data 0xFFFFFFFF -> ex_ready=1, rf_wen stays 0, err stays 0.
- Writeback LD to x9 with no prior issue -> write performed (rf_waddr=9), err=1 and remains 1 until rstn=0.
- Assert rstn=0 in the cycle after a fire -> rf_wen=0 at next edge, all *_busy=0, all ready=0 during reset.
